// File: rtl/psimd_decode_stage.sv
// PSIMD DLFloat decode stage: instruction FIFO, head decoder, 32-entry register
// scoreboard and a registered, back-pressured micro-op output.
module psimd_decode_stage #(
    parameter int DEPTH = 4,
    parameter int LANES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3:0]               out_ena,
    output logic                     out_op,
    output logic [1:0]               out_sel1,
    output logic [2:0]               out_sel2,
    output logic [2:0]               out_rm,
    output logic [4:0]               out_rs1,
    output logic [4:0]               out_rs2,
    output logic [4:0]               out_rs3,
    output logic [4:0]               out_rd,
    output logic [LANES-1:0]         out_lane_en,
    output logic                     out_wr_en,
    output logic                     out_fti_ctrl,
    output logic                     out_sp,
    output logic                     out_illegal,
    input  logic                     wb_valid,
    input  logic [4:0]               wb_rd,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [6:0] OPC_FP    = 7'b1011011;
    localparam logic [6:0] OPC_FMA   = 7'b0011011;
    localparam logic [6:0] OPC_FMS   = 7'b0111011;
    localparam logic [6:0] OPC_STORE = 7'b0101011;

    typedef struct packed {
        logic [3:0]       ena;
        logic             op;
        logic [1:0]       sel1;
        logic [2:0]       sel2;
        logic [2:0]       rm;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rs3;
        logic [4:0]       rd;
        logic [LANES-1:0] lane_en;
        logic             wr_en;
        logic             fti_ctrl;
        logic             sp;
        logic             illegal;
    } uop_t;

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   busy_q, busy_d;
    uop_t          uop_q, dec;
    logic          out_valid_q;

    logic [31:0] instr, wb_mask, eff_busy;
    logic        legal, use_rs2, is_r4, hazard, head_valid, push, pop, fire;

    assign instr      = mem_q[rptr_q];
    assign head_valid = (cnt_q != '0);
    assign in_ready   = (cnt_q < DEPTH_C);

    always_comb begin
        dec          = '0;
        dec.rm       = instr[14:12];
        dec.rs1      = instr[19:15];
        dec.rs2      = instr[24:20];
        dec.rd       = instr[11:7];
        dec.wr_en    = 1'b1;
        dec.fti_ctrl = 1'b1;
        dec.sp       = 1'b1;
        legal        = 1'b1;
        use_rs2      = 1'b1;
        is_r4        = 1'b0;
        case (instr[6:0])
            OPC_FP: begin
                case ({instr[31:27], instr[14:12]})
                    8'b00000_000: dec.ena = 4'b0001;
                    8'b00001_000: begin dec.ena = 4'b0001; dec.op = 1'b1; end
                    8'b00010_000: dec.ena = 4'b0010;
                    8'b00011_000: dec.ena = 4'b0011;
                    8'b01011_000: begin dec.ena = 4'b0100; use_rs2 = 1'b0; end
                    8'b00100_000: begin dec.ena = 4'b0101; dec.sel1 = 2'b01; end
                    8'b00100_001: begin dec.ena = 4'b0101; dec.sel1 = 2'b10; end
                    8'b00100_010: begin dec.ena = 4'b0101; dec.sel1 = 2'b11; end
                    8'b00101_000: begin dec.ena = 4'b0110; dec.sel2 = 3'b001; end
                    8'b00101_001: begin dec.ena = 4'b0110; dec.sel2 = 3'b010; end
                    8'b10100_010: begin dec.ena = 4'b0110; dec.sel2 = 3'b011; end
                    8'b10100_001: begin dec.ena = 4'b0110; dec.sel2 = 3'b100; end
                    8'b10100_000: begin dec.ena = 4'b0110; dec.sel2 = 3'b101; end
                    8'b01001_000: begin dec.ena = 4'b0111; use_rs2 = 1'b0; end
                    8'b01000_000: begin
                        dec.ena = 4'b1000; use_rs2 = 1'b0; dec.fti_ctrl = 1'b0;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_FMA: begin dec.ena = 4'b1001; is_r4 = 1'b1; end
            OPC_FMS: begin dec.ena = 4'b1001; dec.op = 1'b1; is_r4 = 1'b1; end
            OPC_STORE: begin dec.wr_en = 1'b0; dec.sp = 1'b0; end
            default: legal = 1'b0;
        endcase
        case (instr[26:25])
            2'b00:   dec.lane_en = {LANES{1'b1}};
            2'b01:   dec.lane_en = LANES'(1);
            2'b10:   dec.lane_en = {LANES{1'b1}} >> (LANES - LANES / 2);
            default: legal = 1'b0;
        endcase
        if (!use_rs2) dec.rs2 = '0;
        if (is_r4)    dec.rs3 = instr[31:27];
        // Illegal ops still flow to execute so the fault is reported in order,
        // but they carry no unit select, no lanes and no register writes.
        if (!legal) begin
            dec.ena     = '0;
            dec.op      = 1'b0;
            dec.sel1    = '0;
            dec.sel2    = '0;
            dec.rs3     = '0;
            dec.wr_en   = 1'b0;
            dec.lane_en = '0;
            dec.illegal = 1'b1;
            is_r4       = 1'b0;
            use_rs2     = 1'b0;
        end
    end

    assign wb_mask  = wb_valid ? (32'd1 << wb_rd) : 32'd0;
    assign eff_busy = busy_q & ~wb_mask;
    assign hazard   = (legal && eff_busy[dec.rs1])
                    || (use_rs2 && eff_busy[dec.rs2])
                    || (is_r4 && eff_busy[dec.rs3])
                    || (dec.wr_en && eff_busy[dec.rd]);

    assign fire = head_valid && !hazard && (!out_valid_q || out_ready) && !flush;
    assign pop  = fire;
    assign push = in_valid && in_ready && !flush;

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        if (flush) cnt_d = '0;
    end

    // Writeback clears first so an issue to the same register wins.
    always_comb begin
        busy_d = eff_busy;
        if (fire && dec.wr_en) busy_d[dec.rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= in_instr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
            busy_q      <= '0;
            uop_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            if (flush) begin
                wptr_q      <= '0;
                rptr_q      <= '0;
                out_valid_q <= 1'b0;
            end else begin
                if (push) wptr_q <= wptr_q + AW'(1);
                if (pop)  rptr_q <= rptr_q + AW'(1);
                if (fire) begin
                    uop_q       <= dec;
                    out_valid_q <= 1'b1;
                end else if (out_ready) begin
                    out_valid_q <= 1'b0;
                end
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign out_ena      = uop_q.ena;
    assign out_op       = uop_q.op;
    assign out_sel1     = uop_q.sel1;
    assign out_sel2     = uop_q.sel2;
    assign out_rm       = uop_q.rm;
    assign out_rs1      = uop_q.rs1;
    assign out_rs2      = uop_q.rs2;
    assign out_rs3      = uop_q.rs3;
    assign out_rd       = uop_q.rd;
    assign out_lane_en  = uop_q.lane_en;
    assign out_wr_en    = uop_q.wr_en;
    assign out_fti_ctrl = uop_q.fti_ctrl;
    assign out_sp       = uop_q.sp;
    assign out_illegal  = uop_q.illegal;
    assign fifo_count   = cnt_q;

endmodule

// File: tb/tb_psimd_decode_stage.sv
// Directed bench for psimd_decode_stage: hand-computed micro-op fields,
// hazard hold/release, back-pressure, illegal ops, flush and async reset.
module tb_psimd_decode_stage;
    localparam int DEPTH = 4;
    localparam int LANES = 4;

    logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr;
    logic [3:0]  out_ena;
    logic        out_op, out_wr_en, out_fti_ctrl, out_sp, out_illegal, wb_valid;
    logic [1:0]  out_sel1;
    logic [2:0]  out_sel2, out_rm;
    logic [4:0]  out_rs1, out_rs2, out_rs3, out_rd, wb_rd;
    logic [LANES-1:0] out_lane_en;
    logic [$clog2(DEPTH):0] fifo_count;

    int checks = 0;
    int errors = 0;

    psimd_decode_stage #(.DEPTH(DEPTH), .LANES(LANES)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ena(out_ena), .out_op(out_op), .out_sel1(out_sel1), .out_sel2(out_sel2),
        .out_rm(out_rm), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rs3(out_rs3),
        .out_rd(out_rd), .out_lane_en(out_lane_en), .out_wr_en(out_wr_en),
        .out_fti_ctrl(out_fti_ctrl), .out_sp(out_sp), .out_illegal(out_illegal),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] fp(input logic [4:0] f5, input logic [1:0] fmt,
                                       input logic [4:0] rs2, input logic [4:0] rs1,
                                       input logic [2:0] rm, input logic [4:0] rd);
        return {f5, fmt, rs2, rs1, rm, rd, 7'b1011011};
    endfunction

    function automatic logic [31:0] r4(input logic [6:0] opc, input logic [4:0] rs3,
                                       input logic [4:0] rs2, input logic [4:0] rs1,
                                       input logic [4:0] rd);
        return {rs3, 2'b00, rs2, rs1, 3'b000, rd, opc};
    endfunction

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0;
        out_ready = 1'b1; wb_valid = 1'b0; wb_rd = '0;
        #3;
        chk("rst out_valid", out_valid, 0);
        chk("rst in_ready", in_ready, 1);
        chk("rst count", fifo_count, 0);
        chk("rst ena", out_ena, 0);
        chk("rst sp", out_sp, 0);
        chk("rst fti", out_fti_ctrl, 0);
        @(negedge clk); rst_n = 1'b1;
        tick;

        // 1) single add, one-edge latency
        in_valid = 1'b1; in_instr = 32'h0020805B;
        tick;
        in_valid = 1'b0;
        chk("t1 count", fifo_count, 1);
        chk("t1 early valid", out_valid, 0);
        tick;
        chk("t1 valid", out_valid, 1);
        chk("t1 ena", out_ena, 4'b0001);
        chk("t1 op", out_op, 0);
        chk("t1 wr_en", out_wr_en, 1);
        chk("t1 lanes", out_lane_en, 4'b1111);
        chk("t1 rs1", out_rs1, 1);
        chk("t1 rs2", out_rs2, 2);
        chk("t1 rd", out_rd, 0);
        chk("t1 sp", out_sp, 1);
        chk("t1 fti", out_fti_ctrl, 1);
        chk("t1 illegal", out_illegal, 0);
        wb_valid = 1'b1; wb_rd = 5'd0;
        tick;
        wb_valid = 1'b0;
        chk("t1 drop", out_valid, 0);

        // 2) RAW hazard on rd=3, released by same-cycle writeback
        in_valid = 1'b1; in_instr = r4(7'b0011011, 5'd6, 5'd5, 5'd4, 5'd3);
        tick;
        in_instr = fp(5'b00000, 2'b00, 5'd7, 5'd3, 3'b000, 5'd8);
        tick;
        in_valid = 1'b0;
        chk("t2 fma ena", out_ena, 4'b1001);
        chk("t2 fma op", out_op, 0);
        chk("t2 fma rs3", out_rs3, 6);
        chk("t2 fma rd", out_rd, 3);
        tick;
        chk("t2 held valid", out_valid, 0);
        chk("t2 held count", fifo_count, 1);
        tick;
        chk("t2 still held", fifo_count, 1);
        wb_valid = 1'b1; wb_rd = 5'd3;
        tick;
        chk("t2 release valid", out_valid, 1);
        chk("t2 release rs1", out_rs1, 3);
        chk("t2 release rd", out_rd, 8);
        chk("t2 release count", fifo_count, 0);
        wb_rd = 5'd8;
        tick;
        wb_valid = 1'b0;

        // 3) back-pressure: DEPTH in FIFO plus one held in the output register
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            chk("t3 ready before push", in_ready, 1);
            in_valid = 1'b1; in_instr = fp(5'b00010, 2'b00, 5'd11, 5'd10, 3'b000, 5'(12 + i));
            tick;
        end
        chk("t3 full ready", in_ready, 0);
        chk("t3 full count", fifo_count, DEPTH);
        chk("t3 out valid", out_valid, 1);
        chk("t3 out rd", out_rd, 12);
        chk("t3 out ena", out_ena, 4'b0010);
        in_instr = fp(5'b00010, 2'b00, 5'd11, 5'd10, 3'b000, 5'd17);
        tick;
        tick;
        in_valid = 1'b0;
        chk("t3 stable count", fifo_count, DEPTH);
        chk("t3 stable rd", out_rd, 12);
        out_ready = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            tick;
            chk("t3 drain rd", out_rd, 12 + i);
            chk("t3 drain count", fifo_count, DEPTH - i);
        end
        tick;
        chk("t3 drained valid", out_valid, 0);
        wb_valid = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            wb_rd = 5'(12 + i);
            tick;
        end
        wb_valid = 1'b0;

        // 4) illegal opcode and fmt=11; neither marks rd busy
        in_valid = 1'b1; in_instr = {20'h00000, 5'd20, 7'h7F};
        tick;
        in_instr = fp(5'b00000, 2'b11, 5'd2, 5'd1, 3'b000, 5'd21);
        tick;
        chk("t4 ill1 valid", out_valid, 1);
        chk("t4 ill1 flag", out_illegal, 1);
        chk("t4 ill1 ena", out_ena, 0);
        chk("t4 ill1 wr_en", out_wr_en, 0);
        chk("t4 ill1 lanes", out_lane_en, 0);
        in_instr = fp(5'b00000, 2'b00, 5'd21, 5'd20, 3'b000, 5'd22);
        tick;
        in_valid = 1'b0;
        chk("t4 ill2 flag", out_illegal, 1);
        chk("t4 ill2 ena", out_ena, 0);
        chk("t4 ill2 lanes", out_lane_en, 0);
        tick;
        chk("t4 dep valid", out_valid, 1);
        chk("t4 dep legal", out_illegal, 0);
        chk("t4 dep rd", out_rd, 22);
        wb_valid = 1'b1; wb_rd = 5'd22;
        tick;
        wb_valid = 1'b0;

        // 5) rs2-less ops, sign-inject, compare, store
        in_valid = 1'b1; in_instr = fp(5'b01011, 2'b01, 5'd5, 5'd1, 3'b000, 5'd23);
        tick;
        in_instr = fp(5'b01000, 2'b10, 5'd5, 5'd2, 3'b000, 5'd24);
        tick;
        chk("t5 sqrt ena", out_ena, 4'b0100);
        chk("t5 sqrt rs2", out_rs2, 0);
        chk("t5 sqrt lanes", out_lane_en, 4'b0001);
        in_instr = fp(5'b00100, 2'b00, 5'd2, 5'd1, 3'b010, 5'd25);
        tick;
        chk("t5 f2i ena", out_ena, 4'b1000);
        chk("t5 f2i fti", out_fti_ctrl, 0);
        chk("t5 f2i rs2", out_rs2, 0);
        chk("t5 f2i lanes", out_lane_en, 4'b0011);
        in_instr = fp(5'b10100, 2'b00, 5'd2, 5'd1, 3'b010, 5'd26);
        tick;
        chk("t5 sgnjx ena", out_ena, 4'b0101);
        chk("t5 sgnjx sel1", out_sel1, 2'b11);
        chk("t5 sgnjx rm", out_rm, 3'b010);
        in_instr = {5'd0, 2'b00, 5'd2, 5'd1, 3'b010, 5'd9, 7'b0101011};
        tick;
        in_valid = 1'b0;
        chk("t5 eq ena", out_ena, 4'b0110);
        chk("t5 eq sel2", out_sel2, 3'b011);
        tick;
        chk("t5 st valid", out_valid, 1);
        chk("t5 st ena", out_ena, 0);
        chk("t5 st wr_en", out_wr_en, 0);
        chk("t5 st sp", out_sp, 0);
        chk("t5 st illegal", out_illegal, 0);
        tick;

        // 6) flush with 3 queued and one held; scoreboard survives
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_instr = fp(5'b00010, 2'b00, 5'd2, 5'd1, 3'b000, 5'(27 + i));
            tick;
        end
        chk("t6 pre count", fifo_count, 3);
        chk("t6 pre valid", out_valid, 1);
        flush = 1'b1; in_instr = fp(5'b00010, 2'b00, 5'd2, 5'd1, 3'b000, 5'd19);
        tick;
        flush = 1'b0; in_valid = 1'b0;
        chk("t6 flush count", fifo_count, 0);
        chk("t6 flush valid", out_valid, 0);
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = fp(5'b00000, 2'b00, 5'd1, 5'd27, 3'b000, 5'd31);
        tick;
        in_valid = 1'b0;
        tick;
        chk("t6 busy held", out_valid, 0);
        chk("t6 busy count", fifo_count, 1);
        wb_valid = 1'b1; wb_rd = 5'd27;
        tick;
        wb_valid = 1'b0;
        chk("t6 release valid", out_valid, 1);
        chk("t6 release rd", out_rd, 31);
        wb_valid = 1'b1; wb_rd = 5'd31;
        tick;
        wb_valid = 1'b0;

        // 7) asynchronous reset mid-operation
        in_valid = 1'b1; in_instr = fp(5'b00010, 2'b00, 5'd2, 5'd1, 3'b000, 5'd5);
        tick;
        in_instr = fp(5'b00010, 2'b00, 5'd2, 5'd1, 3'b000, 5'd6);
        tick;
        in_valid = 1'b0;
        chk("t7 pre valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t7 rst valid", out_valid, 0);
        chk("t7 rst count", fifo_count, 0);
        chk("t7 rst ready", in_ready, 1);
        chk("t7 rst rd", out_rd, 0);
        #5 rst_n = 1'b1;
        tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
